// File: rtl/bitwise_pkg.sv
// Shared definitions for the registered bitwise ALU slice: opcode encoding
// and the default datapath width.
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  localparam int DEFAULT_WIDTH = 7;

endpackage : bitwise_pkg

// File: rtl/bitwise_core.sv
// Combinational bitwise operator: every result bit depends only on the
// same-index bits of a and b.
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res
);

  // Opcode decode; an unknown op propagates X instead of aliasing a valid op
  always_comb begin
    res = {WIDTH{1'b0}};
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      default: res = {WIDTH{1'bx}};
    endcase
  end

endmodule : bitwise_core

// File: rtl/bitwise_operations.sv
// Registered bitwise ALU slice: one operation per cycle, result on q one
// cycle after the operands are sampled.
module bitwise_operations
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  bitwise_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .op (op),
    .res(q_d)
  );

  // Result register; reset clears it asynchronously and drops any in-flight value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : bitwise_operations

// File: tb/tb_bitwise_operations.sv
// Scoreboard bench for bitwise_operations: expected results are queued when
// operands are driven and compared one clock edge later.
module tb_bitwise_operations;

  logic       clk;
  logic       rst_n;
  logic [6:0] a;
  logic [6:0] b;
  logic [1:0] op;
  logic [6:0] q;

  int         n_vec;
  int         n_err;
  logic [6:0] sb[$];
  logic [6:0] last_exp;

  bitwise_operations #(.WIDTH(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .op   (op),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model(input logic [6:0] x, input logic [6:0] y,
                                       input logic [1:0] o);
    logic [6:0] r;
    r = 7'h00;
    for (int i = 0; i < 7; i++) begin
      if (o == 2'd0)      r[i] = x[i] && y[i];
      else if (o == 2'd1) r[i] = x[i] || y[i];
      else if (o == 2'd2) r[i] = x[i] != y[i];
      else                r[i] = !x[i];
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive operands on the falling edge, queue the expected value, compare after the rising edge
  task automatic step(input string tag, input logic [6:0] ai, input logic [6:0] bi,
                      input logic [1:0] opi, input logic rsti);
    @(negedge clk);
    a     = ai;
    b     = bi;
    op    = opi;
    rst_n = rsti;
    sb.push_back(rsti ? model(ai, bi, opi) : 7'h00);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, q, 7'h00 ^ ~q);
    end else begin
      last_exp = sb.pop_front();
      check_val(tag, q, last_exp);
    end
  endtask

  logic [6:0] ext_a[3];
  logic [6:0] ext_b[3];

  initial begin
    n_vec = 0;
    n_err = 0;
    a = 7'h7F; b = 7'h7F; op = 2'b01; rst_n = 1'b0;
    ext_a[0] = 7'h00; ext_b[0] = 7'h00;
    ext_a[1] = 7'h7F; ext_b[1] = 7'h7F;
    ext_a[2] = 7'h7F; ext_b[2] = 7'h00;

    // reset held, then async assertion mid-cycle
    for (int i = 0; i < 3; i++) step("reset_hold", 7'h7F, 7'h7F, 2'b01, 1'b0);
    step("post_release", 7'h7F, 7'h7F, 2'b01, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset", q, 7'h00);
    step("reset_low", 7'h7F, 7'h7F, 2'b01, 1'b0);

    // directed AND/OR/XOR/NOT
    step("and", 7'b1010101, 7'b1100110, 2'b00, 1'b1);
    check_val("and_const", q, 7'b1000100);
    step("or", 7'b1010101, 7'b1100110, 2'b01, 1'b1);
    check_val("or_const", q, 7'b1110111);
    step("xor", 7'b1010101, 7'b1100110, 2'b10, 1'b1);
    check_val("xor_const", q, 7'b0110011);
    step("not", 7'b1010101, 7'b1100110, 2'b11, 1'b1);
    check_val("not_const", q, 7'b0101010);
    step("not_b0", 7'b1010101, 7'h00, 2'b11, 1'b1);
    check_val("not_b_ignored", q, 7'b0101010);

    // back-to-back with mid-cycle input toggling
    for (int i = 0; i < 16; i++) begin
      step("b2b", 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 2'(i % 4), 1'b1);
      #1;
      a  = 7'($urandom_range(0, 127));
      b  = 7'($urandom_range(0, 127));
      op = 2'($urandom_range(0, 3));
      #1 check_val("hold_midcycle", q, last_exp);
    end

    // extremes for every op
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 3; k++)
        step("extreme", ext_a[k], ext_b[k], 2'(o), 1'b1);
    step("ext_and_ones", 7'h7F, 7'h7F, 2'b00, 1'b1); check_val("ext_and_c", q, 7'h7F);
    step("ext_or_mix",   7'h7F, 7'h00, 2'b01, 1'b1); check_val("ext_or_c", q, 7'h7F);
    step("ext_xor_ones", 7'h7F, 7'h7F, 2'b10, 1'b1); check_val("ext_xor_c", q, 7'h00);
    step("ext_not_zero", 7'h00, 7'h00, 2'b11, 1'b1); check_val("ext_not_c", q, 7'h7F);

    // randomised with reset pulses
    for (int i = 0; i < 1200; i++) begin
      step("random", 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 19) != 0));
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bitwise_operations

// File: doc/bitwise_operations.md
Name: bitwise_operations

Overview:
- Registered 7-bit bitwise ALU slice. Each rising clock edge, it applies the bitwise operation selected by a 2-bit opcode to operands a and b and registers the result on q.
- It is a leaf datapath block for simple operand-processing pipelines and course-style datapath exercises.
- It has no handshake; it accepts a new operation every cycle.

Parameters:
- WIDTH, 7, operand and result width in bits. It must be at least 1. All behaviour below is stated for the default value.

Ports:
- clk    input   1      system clock; all state updates on the rising edge
- rst_n  input   1      asynchronous, active-low reset
- a      input   WIDTH  operand A
- b      input   WIDTH  operand B
- op     input   2      operation select
- q      output  WIDTH  registered result

Behaviour:
- Reset: asserting rst_n low forces q to all zeros immediately, with no clock needed.
- q holds zero while rst_n is low.
- Release of rst_n is sampled synchronously: the first update is at the first rising edge of clk with rst_n high.
- Opcode map, applied bit-for-bit across all WIDTH bits:
  - 2'b00: q <= a & b (AND)
  - 2'b01: q <= a | b (OR)
  - 2'b10: q <= a ^ b (XOR)
  - 2'b11: q <= ~a (NOT of a; b is ignored)
- Latency: exactly 1 cycle.
  - Inputs sampled at rising edge N appear on q after edge N and stay stable until edge N+1.
  - Throughput is one result per cycle.
- q is driven only from a flop; there is no combinational path from any input to q.
- There are no carries or cross-bit dependencies. Bit i of q depends only on bit i of a and b.
- Every opcode value is defined, so no illegal-op handling is needed.
- An X on op must not be silently mapped to a valid operation in simulation. The case statement must cover all 4 values explicitly, and the default branch assigns all-X.
- Reset mid-stream discards any in-flight result. The first post-reset result reflects the inputs at the first edge after release.
- Simultaneous reset assertion and a clock edge: reset wins and q is 0.

Decomposition:
- Shared package bitwise_pkg:
  - op_t, a 2-bit enum: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11
  - constant DEFAULT_WIDTH=7
- One natural sub-module, bitwise_core:
  - purely combinational
  - parameterised by WIDTH
  - inputs a, b, op; output res
- bitwise_operations instantiates bitwise_core and adds the output register with asynchronous reset.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with a=7'h7F, b=7'h7F, op=01 -> q=7'h00 throughout. Then assert rst_n=0 asynchronously mid-cycle while q is nonzero -> q=7'h00 immediately, without waiting for a clock edge.
2. AND/OR: a=7'b1010101, b=7'b1100110.
   - op=00 -> q=7'b1000100 one cycle later.
   - op=01 -> q=7'b1110111.
3. XOR/NOT with the same a and b:
   - op=10 -> q=7'b0110011.
   - op=11 -> q=7'b0101010, and changing b to 7'h00 leaves q unchanged.
4. Latency and back-to-back: change a, b and op on every edge, cycling op 0,1,2,3. Each q must equal the reference model of the previous edge's inputs. Check that q does not change between edges when inputs toggle mid-cycle.
5. Extremes for every op, using (a,b) pairs {00,00}, {7F,7F}, {7F,00} -> expected values:
   - AND: 00, 7F, 00
   - OR: 00, 7F, 7F
   - XOR: 00, 00, 7F
   - NOT: 7F, 00, 00
6. Randomised: at least 1000 cycles of random a, b, op, with random rst_n pulses. Compare q against the reference model every cycle, including the first cycle after each reset release.
